// File: rtl/bcd_count_scan.sv
// bcd_count_scan: 4-digit packed-BCD event counter with a time-multiplexed
// single-digit output bus and active-low one-hot anode select.
// Optional build macro: BCD_LEADING_ZERO_BLANK_EN blanks leading-zero digits
// (slots 1..3) by driving select to 4'b1111; the ones digit is never blanked.
module bcd_count_scan #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_in,
  input  logic        up,
  input  logic        clr,
  output logic [15:0] value,
  output logic        wrap,
  output logic [3:0]  digit_out,
  output logic [3:0]  select
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

  logic          count_prev;
  logic          step;
  logic [15:0]   value_next;
  logic          wrap_next;
  logic [PW-1:0] pre;
  logic [1:0]    scan_idx;
  logic [3:0]    sel_next;
  logic [3:0]    digit_next;

  assign step = count_in & ~count_prev;

  // Ripple BCD increment/decrement; carry out of the thousands digit is the wrap.
  always_comb begin
    logic       ripple;
    logic [3:0] nib;
    value_next = value;
    ripple     = 1'b1;
    nib        = 4'h0;
    for (int i = 0; i < 4; i++) begin
      nib = value[4*i +: 4];
      if (ripple) begin
        if (up) begin
          if (nib == 4'd9) begin
            value_next[4*i +: 4] = 4'd0;
          end else begin
            value_next[4*i +: 4] = nib + 4'd1;
            ripple = 1'b0;
          end
        end else begin
          if (nib == 4'd0) begin
            value_next[4*i +: 4] = 4'd9;
          end else begin
            value_next[4*i +: 4] = nib - 4'd1;
            ripple = 1'b0;
          end
        end
      end
    end
    wrap_next = ripple;
  end

  // Edge history and counter register; history resets high so a level held
  // through reset is not taken as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_prev <= 1'b1;
      value      <= 16'h0000;
      wrap       <= 1'b0;
    end else begin
      count_prev <= count_in;
      if (clr) begin
        value <= 16'h0000;
        wrap  <= 1'b0;
      end else if (step) begin
        value <= value_next;
        wrap  <= wrap_next;
      end else begin
        wrap  <= 1'b0;
      end
    end
  end

  // Slot prescaler and scan index; independent of counting and clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre      <= '0;
      scan_idx <= 2'd0;
    end else if (pre == PRE_LAST) begin
      pre      <= '0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      pre      <= pre + 1'b1;
    end
  end

  // Digit mux and anode select for the current slot.
  always_comb begin
    sel_next   = 4'b1110;
    digit_next = value[3:0];
    case (scan_idx)
      2'd0: begin sel_next = 4'b1110; digit_next = value[3:0];   end
      2'd1: begin sel_next = 4'b1101; digit_next = value[7:4];   end
      2'd2: begin sel_next = 4'b1011; digit_next = value[11:8];  end
      default: begin sel_next = 4'b0111; digit_next = value[15:12]; end
    endcase
`ifdef BCD_LEADING_ZERO_BLANK_EN
    if ((scan_idx == 2'd1 && value[15:4]  == 12'h000) ||
        (scan_idx == 2'd2 && value[15:8]  == 8'h00)   ||
        (scan_idx == 2'd3 && value[15:12] == 4'h0)) begin
      sel_next = 4'b1111;
    end
`endif
  end

  // Registered scan outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      select    <= 4'b1110;
      digit_out <= 4'h0;
    end else begin
      select    <= sel_next;
      digit_out <= digit_next;
    end
  end

endmodule

// File: tb/tb_bcd_count_scan.sv
// Directed testbench for bcd_count_scan with REFRESH_DIV=4.
module tb_bcd_count_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        count_in = 1'b1;
  logic        up = 1'b1;
  logic        clr = 1'b0;
  logic [15:0] value;
  logic        wrap;
  logic [3:0]  digit_out;
  logic [3:0]  select;

  int n_cmp = 0;
  int n_err = 0;

  bcd_count_scan #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .count_in(count_in), .up(up), .clr(clr),
    .value(value), .wrap(wrap), .digit_out(digit_out), .select(select)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic dir);
    @(negedge clk);
    up = dir;
    count_in = 1'b1;
    @(negedge clk);
    count_in = 1'b0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) pulse(1'b1);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Returns at the negedge where select first shows 1110 after another pattern.
  task automatic sync_slot0(input string tag);
    logic [3:0] prev;
    bit found;
    found = 0;
    @(negedge clk);
    prev = select;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (select == 4'b1110 && prev != 4'b1110) found = 1;
      prev = select;
    end
    if (!found) check_val({tag, "_sync_timeout"}, 16'd0, 16'd1);
  endtask

  // Checks four full slots starting in slot 0 against the display rules.
  task automatic check_scan(input string tag, input logic [15:0] v);
    logic [3:0] exp_sel;
    logic [3:0] exp_dig;
    int slot;
    sync_slot0(tag);
    for (int j = 0; j < 16; j++) begin
      slot = j / 4;
      exp_sel = ~(4'b0001 << slot);
      exp_dig = v[4*slot +: 4];
`ifdef BCD_LEADING_ZERO_BLANK_EN
      if (slot > 0 && (v >> (4*slot)) == 16'h0000) exp_sel = 4'b1111;
`endif
      check_val($sformatf("%s_sel%0d", tag, j), {12'h0, select}, {12'h0, exp_sel});
      check_val($sformatf("%s_dig%0d", tag, j), {12'h0, digit_out}, {12'h0, exp_dig});
      @(negedge clk);
    end
  endtask

  initial begin
    // 1: reset with count_in held high, release with it still high
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_sel", {12'h0, select}, 16'h000e);
    check_val("rst_dig", {12'h0, digit_out}, 16'h0000);
    check_val("rst_val", value, 16'h0000);
    check_val("rst_wrap", {15'h0, wrap}, 16'h0000);
    repeat (2) @(negedge clk);
    check_val("rst_nocount", value, 16'h0000);

    // 2: twelve pulses, then a long high level counting once
    count_in = 1'b0;
    pulses(12);
    check_val("pulse12", value, 16'h0012);
    @(negedge clk);
    count_in = 1'b1;
    repeat (10) @(negedge clk);
    check_val("held_high", value, 16'h0013);
    count_in = 1'b0;

    // 3: ripple carry, underflow and overflow wraps
    do_clr();
    check_val("clr_val", value, 16'h0000);
    pulses(999);
    check_val("v0999", value, 16'h0999);
    pulse(1'b1);
    check_val("v1000", value, 16'h1000);
    check_val("v1000_wrap", {15'h0, wrap}, 16'h0000);
    do_clr();
    pulse(1'b0);
    check_val("v9999", value, 16'h9999);
    check_val("v9999_wrap", {15'h0, wrap}, 16'h0001);
    @(negedge clk);
    check_val("v9999_wrap_end", {15'h0, wrap}, 16'h0000);
    pulse(1'b1);
    check_val("v0000", value, 16'h0000);
    check_val("v0000_wrap", {15'h0, wrap}, 16'h0001);
    @(negedge clk);
    check_val("v0000_wrap_end", {15'h0, wrap}, 16'h0000);

    // 4: scan of 0x1234, two rounds, then reset mid-slot
    pulses(1234);
    check_val("v1234", value, 16'h1234);
    check_scan("scan1234a", 16'h1234);
    check_scan("scan1234b", 16'h1234);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("midrst_sel", {12'h0, select}, 16'h000e);
    check_val("midrst_dig", {12'h0, digit_out}, 16'h0000);
    check_val("midrst_val", value, 16'h0000);

    // 5: clr and a rising edge together; scan timing undisturbed
    pulses(456);
    check_val("v0456", value, 16'h0456);
    sync_slot0("clrstep");
    clr = 1'b1;
    count_in = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    count_in = 1'b0;
    check_val("clrstep_val", value, 16'h0000);
    check_val("clrstep_wrap", {15'h0, wrap}, 16'h0000);
    @(negedge clk);
    check_val("clrstep_sel_hold", {12'h0, select}, 16'h000e);
    check_val("clrstep_dig", {12'h0, digit_out}, 16'h0000);
    @(negedge clk);
    check_val("clrstep_sel_hold2", {12'h0, select}, 16'h000e);
    @(negedge clk);
`ifdef BCD_LEADING_ZERO_BLANK_EN
    check_val("clrstep_sel_next", {12'h0, select}, 16'h000f);
`else
    check_val("clrstep_sel_next", {12'h0, select}, 16'h000d);
`endif

    // 6: leading-zero handling for 0x0007 and 0x0000
    pulses(7);
    check_val("v0007", value, 16'h0007);
    check_scan("scan0007", 16'h0007);
    do_clr();
    check_scan("scan0000", 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
